// File: rtl/mem_responder.sv
// Single-port 256x8 memory responder with a valid/ready request side and a
// held response; a programmable number of wait cycles precedes every response.
module mem_responder #(
   parameter int WAIT_STATES = 1,
   parameter bit INIT_ZERO   = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic       req_we,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       req_ready,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   input  logic       rsp_ready,
   output logic       stall
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   state_t     state_r;
   state_t     state_n;
   logic [3:0] cnt_r;
   logic [7:0] addr_r;
   logic [7:0] wdata_r;
   logic       we_r;
   logic       ready_r;
   logic       rsp_valid_r;
   logic [7:0] rsp_rdata_r;

   logic       accept_s;
   logic       enter_resp_s;
   logic       commit_s;
   logic       acc_we_s;
   logic [7:0] acc_addr_s;
   logic [7:0] acc_wdata_s;
   logic [7:0] mem_rd_s;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state decode.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               state_n = (WAIT_INIT == 4'd0) ? RESP : WAIT;
            end else begin
               state_n = IDLE;
            end
         end
         WAIT: begin
            // <= 1 rather than == 1 so a corrupted zero count cannot hang here
            if (cnt_r <= 4'd1) begin
               state_n = RESP;
            end else begin
               state_n = WAIT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_n = IDLE;
            end else begin
               state_n = RESP;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Output/control decode; with zero wait states the access is served straight
   // from the request inputs on the handshake edge, otherwise from the latches.
   always_comb begin
      accept_s     = 1'b0;
      acc_we_s     = we_r;
      acc_addr_s   = addr_r;
      acc_wdata_s  = wdata_r;
      if (state_r == IDLE) begin
         accept_s    = req_valid;
         acc_we_s    = req_we;
         acc_addr_s  = req_addr;
         acc_wdata_s = req_wdata;
      end else begin
         accept_s    = 1'b0;
      end
      enter_resp_s = (state_n == RESP) && (state_r != RESP);
      commit_s     = enter_resp_s && acc_we_s;
   end

   // Storage: never touched by reset, so contents survive aborted accesses.
   generate
      if (INIT_ZERO) begin : g_mem
         logic [7:0] mem_r [256] = '{default: 8'h00};

         // Write port, committed only on entry to RESP.
         always_ff @(posedge clk) begin
            if (commit_s) begin
               mem_r[acc_addr_s] <= acc_wdata_s;
            end
         end
         assign mem_rd_s = mem_r[acc_addr_s];
      end else begin : g_mem
         logic [7:0] mem_r [256];

         // Write port, committed only on entry to RESP.
         always_ff @(posedge clk) begin
            if (commit_s) begin
               mem_r[acc_addr_s] <= acc_wdata_s;
            end
         end
         assign mem_rd_s = mem_r[acc_addr_s];
      end
   endgenerate

   // Request latches, wait counter and registered response/ready outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r       <= 4'd0;
         addr_r      <= 8'h00;
         wdata_r     <= 8'h00;
         we_r        <= 1'b0;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 8'h00;
      end else begin
         if (accept_s) begin
            addr_r  <= req_addr;
            we_r    <= req_we;
            wdata_r <= req_wdata;
            cnt_r   <= WAIT_INIT;
         end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
         end
         if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= acc_we_s ? acc_wdata_s : mem_rd_s;
         end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
         end
         ready_r <= (state_n == IDLE);
      end
   end

   assign req_ready = ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign stall     = req_valid & ~ready_r;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Parameters
REQ-001 SHALL provide parameter WAIT_STATES, default 1, meaning the number of idle cycles inserted between accepting a request and presenting its response (legal range 0..15).
REQ-002 SHALL provide parameter INIT_ZERO, default 0, meaning when 1 the simulation-time initial memory content is all 0x00.

Interface
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, meaning the pipeline presents an access.
REQ-006 SHALL have port req_we, input, 1, meaning 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, 8, the memory byte address produced by the pipeline address selector.
REQ-008 SHALL have port req_wdata, input, 8, the store data.
REQ-009 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-010 SHALL have port rsp_valid, output, 1, meaning rsp_rdata is valid.
REQ-011 SHALL have port rsp_rdata, output, 8, the read data, or the written data echoed for writes.
REQ-012 SHALL have port rsp_ready, input, 1, meaning the pipeline consumes the response.
REQ-013 SHALL have port stall, output, 1, equal to req_valid AND NOT req_ready, combinational.

Function
REQ-014 SHALL contain 256 x 8-bit storage addressed by req_addr with no address wrap logic, so 0x00..0xFF all map directly.
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A handshake SHALL occur on a rising edge with req_valid=1 and req_ready=1.
- Latch addr, we and wdata at the handshake.
- Go to WAIT with counter = WAIT_STATES, or go directly to RESP if WAIT_STATES = 0.
REQ-018 In WAIT the counter SHALL decrement once per cycle; when it equals 1, the next state SHALL be RESP.
REQ-019 On the transition into RESP:
- A write SHALL commit mem[addr] <= wdata and load rsp_rdata <= wdata.
- A read SHALL load rsp_rdata <= mem[addr].
- rsp_valid SHALL be set to 1.
REQ-020 Latency SHALL be exactly WAIT_STATES+1 cycles from the handshake edge to the first cycle with rsp_valid=1.
REQ-021 In RESP, rsp_valid and rsp_rdata SHALL hold stable until a rising edge with rsp_ready=1; that edge SHALL clear rsp_valid and return to IDLE.
REQ-022 No new request SHALL be accepted in the same cycle that a response completes, so the minimum issue interval is WAIT_STATES+2 cycles.
REQ-023 A read to an address written by the immediately preceding completed write SHALL return the newly written value.
REQ-024 Request inputs changing while not in IDLE SHALL have no effect.
REQ-025 req_we, req_addr and req_wdata SHALL be ignored when req_valid=0.

Reset
REQ-026 While reset_n=0, regardless of clk:
- state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0x00, latched addr/we/wdata = 0.
- req_ready = 1 after reset.
REQ-027 Memory contents SHALL NOT be altered by reset.
REQ-028 Reset asserted in WAIT SHALL abort the access, and a pending write SHALL NOT commit.
REQ-029 Reset asserted in RESP SHALL drop the response, and an already-committed write SHALL remain.
REQ-030 The first request SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-031 Reset then idle: reset_n=0 mid-cycle -> immediately rsp_valid=0, rsp_rdata=0x00, req_ready=1, stall=0.
REQ-032 Write then read with WAIT_STATES=1, rsp_ready held 1:
- Write 0xA5 to addr 0x3C -> rsp_valid at cycle 2 with rsp_rdata=0xA5.
- Read of 0x3C -> rsp_rdata=0xA5 after 2 cycles.
REQ-033 Backpressure: read 0xFF with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles; stall=1 for a second request presented during that time; IDLE is reached one edge after rsp_ready=1.
REQ-034 WAIT_STATES=0 build: write 0x11 to 0x00, then read 0x00 -> each rsp_valid appears 1 cycle after its handshake; read data = 0x11.
REQ-035 Reset mid-write with WAIT_STATES=3:
- Write 0x77 to 0x10, where 0x10 previously held 0x22.
- Assert reset_n=0 in the second WAIT cycle.
- A subsequent read of 0x10 -> returns 0x22.
REQ-036 Boundary addresses: write 0x5A to 0xFF and 0xC3 to 0x00 -> reads return 0x5A and 0xC3 respectively, with no aliasing between them.
